// File: rtl/tucanos_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tucanos_scheduler
// Purpose  : Round-robin, quantum-based process scheduler that raises OS jump
//            requests on I/O waits, halts, context changes and idle periods.
// Revision : 1.0 - initial release
// ============================================================================
module tucanos_scheduler #(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_PROCS     = 3,
   parameter int COUNTER_WIDTH = 8,
   parameter int PC_WIDTH      = 12,
   parameter int OS_BEGIN_ADDR = 256
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [5:0]               opcode,
   input  logic [PC_WIDTH-1:0]      program_counter,
   input  logic                     mux_system_instruction,
   input  logic [COUNTER_WIDTH-1:0] quantum,
   input  logic [NUM_PROCS-1:0]     io_done,
   output logic [DATA_WIDTH-1:0]    state_register,
   output logic                     jump_enabler,
   output logic [3:0]               current_process,
   output logic [2*NUM_PROCS-1:0]   process_status
);

   localparam logic [5:0] OP_HLT   = 6'b011100;
   localparam logic [5:0] OP_PREIO = 6'b011110;

   localparam logic [DATA_WIDTH-1:0] DISABLED    = '0;
   localparam logic [DATA_WIDTH-1:0] WAIT_ENABLE = DATA_WIDTH'(NUM_PROCS + 1);
   localparam logic [DATA_WIDTH-1:0] HALT_ENABLE = DATA_WIDTH'(NUM_PROCS + 2);
   localparam logic [DATA_WIDTH-1:0] IDLE_CODE   = DATA_WIDTH'(NUM_PROCS + 3);

   localparam logic [1:0] ST_READY   = 2'b00;
   localparam logic [1:0] ST_WAITING = 2'b01;
   localparam logic [1:0] ST_HALTED  = 2'b10;

   typedef enum logic [2:0] {
      COUNTING = 3'd0,
      WAIT     = 3'd1,
      HALT     = 3'd2,
      CHANGE   = 3'd3,
      IDLE     = 3'd4
   } state_t;

   state_t                     state;
   logic [COUNTER_WIDTH-1:0]   counter;
   logic [1:0]                 status    [NUM_PROCS];
   logic [1:0]                 status_io [NUM_PROCS];
   logic [1:0]                 status_ev [NUM_PROCS];
   logic [COUNTER_WIDTH-1:0]   quantum_eff;
   logic                       gated;
   logic                       is_preio;
   logic                       is_hlt;
   logic                       expired;
   logic [4:0]                 cand;
   logic [3:0]                 next_proc;
   logic                       next_found;

   assign jump_enabler = (state != COUNTING);

   always_comb begin
      quantum_eff = (quantum == '0) ? COUNTER_WIDTH'(1) : quantum;
      gated       = mux_system_instruction &&
                    (32'(program_counter) < 32'(OS_BEGIN_ADDR));
      is_preio    = (state == COUNTING) && (opcode == OP_PREIO);
      is_hlt      = (state == COUNTING) && (opcode == OP_HLT);
      expired     = (counter >= quantum_eff);

      // I/O completion is applied before the running process's own event,
      // so a simultaneous PREIO still leaves that process WAITING.
      for (int k = 0; k < NUM_PROCS; k++) begin
         status_io[k] = status[k];
         if (status[k] == ST_WAITING && io_done[k])
            status_io[k] = ST_READY;
         status_ev[k] = status_io[k];
         if (current_process == 4'(k + 1)) begin
            if (is_preio)
               status_ev[k] = ST_WAITING;
            else if (is_hlt)
               status_ev[k] = ST_HALTED;
         end
      end

      // Round robin starting after the running process and wrapping onto it.
      cand       = '0;
      next_proc  = '0;
      next_found = 1'b0;
      for (int o = 1; o <= NUM_PROCS; o++) begin
         cand = 5'(current_process) + 5'(o);
         if (cand > 5'(NUM_PROCS))
            cand = cand - 5'(NUM_PROCS);
         for (int k = 0; k < NUM_PROCS; k++) begin
            if (!next_found && cand == 5'(k + 1) && status_ev[k] == ST_READY) begin
               next_found = 1'b1;
               next_proc  = 4'(cand);
            end
         end
      end

      for (int k = 0; k < NUM_PROCS; k++)
         process_status[2*k +: 2] = status[k];
   end

   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         state           <= COUNTING;
         counter         <= '0;
         state_register  <= DISABLED;
         current_process <= '0;
         for (int k = 0; k < NUM_PROCS; k++)
            status[k] <= ST_READY;
      end else if (!gated) begin
         state   <= COUNTING;
         counter <= '0;
         status  <= status_io;
      end else begin
         status <= status_ev;
         case (state)
            COUNTING: begin
               if (opcode == OP_PREIO) begin
                  state           <= WAIT;
                  state_register  <= WAIT_ENABLE;
                  counter         <= '0;
                  current_process <= next_proc;
               end else if (opcode == OP_HLT) begin
                  state           <= HALT;
                  state_register  <= HALT_ENABLE;
                  counter         <= '0;
                  current_process <= next_proc;
               end else if (expired) begin
                  counter <= '0;
                  if (next_found) begin
                     state           <= CHANGE;
                     state_register  <= DATA_WIDTH'(next_proc);
                     current_process <= next_proc;
                  end else begin
                     state           <= IDLE;
                     state_register  <= IDLE_CODE;
                     current_process <= '0;
                  end
               end else begin
                  counter        <= (counter == '1) ? counter : counter + 1'b1;
                  state_register <= DISABLED;
               end
            end
            WAIT, HALT, CHANGE: begin
               state   <= COUNTING;
               counter <= '0;
            end
            IDLE: begin
               counter <= '0;
               if (next_found) begin
                  state           <= CHANGE;
                  state_register  <= DATA_WIDTH'(next_proc);
                  current_process <= next_proc;
               end else begin
                  state_register  <= IDLE_CODE;
               end
            end
            default: begin
               state   <= COUNTING;
               counter <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tucanos_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tucanos_scheduler
// Purpose  : Directed self-checking bench for tucanos_scheduler (3 processes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tucanos_scheduler;

   localparam logic [5:0] NOP   = 6'b000000;
   localparam logic [5:0] HLT   = 6'b011100;
   localparam logic [5:0] PREIO = 6'b011110;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [5:0]  opcode = NOP;
   logic [11:0] program_counter = '0;
   logic        mux_system_instruction = 1'b1;
   logic [7:0]  quantum = 8'd7;
   logic [2:0]  io_done = '0;
   logic [31:0] state_register;
   logic        jump_enabler;
   logic [3:0]  current_process;
   logic [5:0]  process_status;

   int checks = 0;
   int errors = 0;
   logic [42:0] exp;

   always #5 clock = ~clock;

   tucanos_scheduler #(
      .DATA_WIDTH(32), .NUM_PROCS(3), .COUNTER_WIDTH(8),
      .PC_WIDTH(12), .OS_BEGIN_ADDR(256)
   ) dut (
      .clock(clock),
      .reset(reset),
      .opcode(opcode),
      .program_counter(program_counter),
      .mux_system_instruction(mux_system_instruction),
      .quantum(quantum),
      .io_done(io_done),
      .state_register(state_register),
      .jump_enabler(jump_enabler),
      .current_process(current_process),
      .process_status(process_status)
   );

   // Observed outputs packed as {state_register, current_process, jump, status}.
   function automatic logic [42:0] snap();
      return {state_register, current_process, jump_enabler, process_status};
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clock);
      #1;
   endtask

   task automatic do_reset(input logic [7:0] q);
      opcode = NOP; io_done = '0; program_counter = '0;
      mux_system_instruction = 1'b1; quantum = q;
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      exp = {32'd0, 4'd0, 1'b0, 6'b000000};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL reset_state: got %h expected %h", snap(), exp);
      end
      reset = 1'b0;
      do_reset(8'd7);
   endtask

   task automatic test_first_switch();
      for (int i = 0; i < 7; i++) begin
         tick();
         exp = {32'd0, 4'd0, 1'b0, 6'b000000};
         checks++;
         if (snap() !== exp) begin
            errors++; $display("FAIL first_switch_count%0d: got %h expected %h", i, snap(), exp);
         end
      end
      tick();
      exp = {32'd1, 4'd1, 1'b1, 6'b000000};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL first_switch_change: got %h expected %h", snap(), exp);
      end
      tick();
      exp = {32'd1, 4'd1, 1'b0, 6'b000000};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL first_switch_return: got %h expected %h", snap(), exp);
      end
   endtask

   task automatic test_preio_io();
      opcode = PREIO; tick(); opcode = NOP;
      exp = {32'd4, 4'd2, 1'b1, 6'b000001};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL preio_wait: got %h expected %h", snap(), exp);
      end
      tick();
      exp = {32'd4, 4'd2, 1'b0, 6'b000001};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL preio_return: got %h expected %h", snap(), exp);
      end
      io_done = 3'b001; tick(); io_done = '0;
      exp = {32'd0, 4'd2, 1'b0, 6'b000000};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL io_done_ready: got %h expected %h", snap(), exp);
      end
   endtask

   task automatic test_halt_idle();
      opcode = HLT; tick(); opcode = NOP;
      exp = {32'd5, 4'd3, 1'b1, 6'b001000};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL halt_p2: got %h expected %h", snap(), exp);
      end
      tick();
      opcode = HLT; tick(); opcode = NOP;
      exp = {32'd5, 4'd1, 1'b1, 6'b101000};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL halt_p3: got %h expected %h", snap(), exp);
      end
      tick();
      opcode = HLT; tick(); opcode = NOP;
      exp = {32'd5, 4'd0, 1'b1, 6'b101010};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL halt_last: got %h expected %h", snap(), exp);
      end
      tick(8);
      exp = {32'd5, 4'd0, 1'b0, 6'b101010};
      checks++;
      // Pre-expiry edges overwrite state_register with DISABLED.
      exp[42:11] = 32'd0;
      if (snap() !== exp) begin
         errors++; $display("FAIL halt_counting: got %h expected %h", snap(), exp);
      end
      tick();
      exp = {32'd6, 4'd0, 1'b1, 6'b101010};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL idle_enter: got %h expected %h", snap(), exp);
      end
      tick();
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL idle_hold: got %h expected %h", snap(), exp);
      end
      // Leave IDLE through an ungated edge, then PREIO with no process running.
      program_counter = 12'd300; tick(); program_counter = '0;
      exp = {32'd6, 4'd0, 1'b0, 6'b101010};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL ungated_exit_idle: got %h expected %h", snap(), exp);
      end
      opcode = PREIO; tick(); opcode = NOP;
      exp = {32'd4, 4'd0, 1'b1, 6'b101010};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL preio_no_process: got %h expected %h", snap(), exp);
      end
      tick();
   endtask

   task automatic test_ungated();
      program_counter = 12'd300;
      for (int i = 0; i < 20; i++) begin
         tick();
         exp = {32'd4, 4'd0, 1'b0, 6'b101010};
         checks++;
         if (snap() !== exp) begin
            errors++; $display("FAIL ungated_hold%0d: got %h expected %h", i, snap(), exp);
         end
      end
      program_counter = 12'd16;
      tick(7);
      exp = {32'd0, 4'd0, 1'b0, 6'b101010};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL ungated_counter_cleared: got %h expected %h", snap(), exp);
      end
      tick();
      exp = {32'd6, 4'd0, 1'b1, 6'b101010};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL ungated_then_expire: got %h expected %h", snap(), exp);
      end
   endtask

   task automatic test_same_edge_and_wakeup();
      do_reset(8'd7);
      tick(9);
      opcode = PREIO; tick(); opcode = NOP;
      tick();
      opcode = PREIO; io_done = 3'b011; tick(); opcode = NOP; io_done = '0;
      exp = {32'd4, 4'd3, 1'b1, 6'b000100};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL io_preio_same_edge: got %h expected %h", snap(), exp);
      end
      tick();
      opcode = PREIO; tick(); opcode = NOP;
      exp = {32'd4, 4'd1, 1'b1, 6'b010100};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL preio_wrap_to_p1: got %h expected %h", snap(), exp);
      end
      tick();
      opcode = PREIO; tick(); opcode = NOP;
      exp = {32'd4, 4'd0, 1'b1, 6'b010101};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL preio_all_waiting: got %h expected %h", snap(), exp);
      end
      tick(9);
      exp = {32'd6, 4'd0, 1'b1, 6'b010101};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL idle_all_waiting: got %h expected %h", snap(), exp);
      end
      io_done = 3'b100; tick(); io_done = '0;
      exp = {32'd3, 4'd3, 1'b1, 6'b000101};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL idle_wakeup: got %h expected %h", snap(), exp);
      end
      tick();
      exp = {32'd3, 4'd3, 1'b0, 6'b000101};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL wakeup_return: got %h expected %h", snap(), exp);
      end
   endtask

   task automatic test_quantum_zero_reset();
      logic [42:0] seq [5];
      seq[0] = {32'd0, 4'd0, 1'b0, 6'b000000};
      seq[1] = {32'd1, 4'd1, 1'b1, 6'b000000};
      seq[2] = {32'd1, 4'd1, 1'b0, 6'b000000};
      seq[3] = {32'd0, 4'd1, 1'b0, 6'b000000};
      seq[4] = {32'd2, 4'd2, 1'b1, 6'b000000};
      do_reset(8'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (snap() !== seq[i]) begin
            errors++; $display("FAIL quantum_zero_edge%0d: got %h expected %h", i, snap(), seq[i]);
         end
      end
      reset = 1'b1;
      #1;
      exp = {32'd0, 4'd0, 1'b0, 6'b000000};
      checks++;
      if (snap() !== exp) begin
         errors++; $display("FAIL reset_during_change: got %h expected %h", snap(), exp);
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_first_switch();
      test_preio_io();
      test_halt_idle();
      test_ungated();
      test_same_edge_and_wakeup();
      test_quantum_zero_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
